// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 nonce engine: FSM encoding, round
// constants, block padding words and the FIPS 180-4 logical functions.
package sha256_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ROUND = 3'd1,
    ST_FINAL = 3'd2,
    ST_OUT   = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Padding word after the nonce and the 640-bit message length word.
  localparam logic [31:0] PAD_WORD = 32'h8000_0000;
  localparam logic [31:0] LEN_WORD = 32'h0000_0280;

  localparam logic [31:0] K_TABLE [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] ch_f(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj_f(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b00_0000_0000, x[31:10]};
  endfunction

  // Word-wise modulo 2^32 addition of two eight-word hash states.
  function automatic logic [255:0] add_words(input logic [255:0] x, input logic [255:0] y);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[i*32 +: 32] = x[i*32 +: 32] + y[i*32 +: 32];
    end
    return r;
  endfunction

endpackage

// File: rtl/sha256_nonce_engine_if.sv
// Bus between the SPI receive stage, the nonce engine and the downstream
// compare stage. The engine uses the slave modport.
interface sha256_nonce_engine_if;
  logic         start;
  logic         stop;
  logic [255:0] h_prev;
  logic [95:0]  msg_tail;
  logic         busy;
  logic         digest_valid;
  logic         digest_ready;
  logic [255:0] digest;
  logic [31:0]  digest_nonce;
  logic         done;

  modport slave (
    input  start, stop, h_prev, msg_tail, digest_ready,
    output busy, digest_valid, digest, digest_nonce, done
  );

  modport master (
    output start, stop, h_prev, msg_tail, digest_ready,
    input  busy, digest_valid, digest, digest_nonce, done
  );
endinterface

// File: rtl/sha256_round.sv
// One combinational SHA-256 round plus the next message-schedule word.
// state_in/state_out carry a..h with word a in [255:224].
module sha256_round
  import sha256_pkg::*;
(
  input  logic [255:0] state_in,
  input  logic [31:0]  w_t,
  input  logic [31:0]  k_t,
  input  logic [31:0]  w_t1,
  input  logic [31:0]  w_t9,
  input  logic [31:0]  w_t14,
  output logic [255:0] state_out,
  output logic [31:0]  w_next
);

  logic [31:0] a_s, b_s, c_s, d_s, e_s, f_s, g_s, h_s;
  logic [31:0] t1_s, t2_s;

  // Compression step and schedule extension W[t+16] from the sliding window.
  always_comb begin
    {a_s, b_s, c_s, d_s, e_s, f_s, g_s, h_s} = state_in;
    t1_s = h_s + big_sigma1(e_s) + ch_f(e_s, f_s, g_s) + k_t + w_t;
    t2_s = big_sigma0(a_s) + maj_f(a_s, b_s, c_s);
    state_out = {t1_s + t2_s, a_s, b_s, c_s, d_s + t1_s, e_s, f_s, g_s};
    w_next = small_sigma1(w_t14) + w_t9 + small_sigma0(w_t1) + w_t;
  end

endmodule

// File: rtl/sha256_nonce_engine.sv
// Iterative SHA-256 nonce sweeper: builds the second header block for each
// nonce, compresses it at one round per cycle and hands midstate+state to
// the next stage over a valid/ready handshake.
// Optional build macro NONCE_BYTESWAP_EN: place the nonce byte-swapped in W3.
module sha256_nonce_engine
  import sha256_pkg::*;
#(
  parameter logic [31:0] NONCE_START = 32'h0000_0000,
  parameter logic [31:0] NONCE_END   = 32'hFFFF_FFFF
)
(
  input logic clk,
  input logic reset,
  sha256_nonce_engine_if.slave bus
);

  state_e state_r, state_next_s;

  logic [255:0]      hp_r;
  logic [95:0]       tail_r;
  logic [31:0]       nonce_r;
  logic [255:0]      st_r;
  logic [15:0][31:0] w_r;
  logic [5:0]        t_r;
  logic [255:0]      digest_r;
  logic [31:0]       digest_nonce_r;
  logic              digest_valid_r;
  logic              done_r;
  logic              busy_r;

  logic              load_start_s;
  logic              load_next_s;
  logic              round_en_s;
  logic              final_s;
  logic              done_set_s;
  logic [255:0]      rnd_state_s;
  logic [31:0]       w_next_s;

  // Second header block: tail words, nonce, padding, zeros, length.
  function automatic logic [15:0][31:0] build_block(input logic [95:0] tail, input logic [31:0] n);
    logic [15:0][31:0] blk;
    blk     = '0;
    blk[0]  = tail[95:64];
    blk[1]  = tail[63:32];
    blk[2]  = tail[31:0];
`ifdef NONCE_BYTESWAP_EN
    blk[3]  = {n[7:0], n[15:8], n[23:16], n[31:24]};
`else
    blk[3]  = n;
`endif
    blk[4]  = PAD_WORD;
    blk[15] = LEN_WORD;
    return blk;
  endfunction

  sha256_round u_round (
    .state_in  (st_r),
    .w_t       (w_r[0]),
    .k_t       (K_TABLE[t_r]),
    .w_t1      (w_r[1]),
    .w_t9      (w_r[9]),
    .w_t14     (w_r[14]),
    .state_out (rnd_state_s),
    .w_next    (w_next_s)
  );

  // Next-state decode and datapath strobes; stop overrides any handshake.
  always_comb begin
    state_next_s = state_r;
    load_start_s = 1'b0;
    load_next_s  = 1'b0;
    round_en_s   = 1'b0;
    final_s      = 1'b0;
    done_set_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          load_start_s = 1'b1;
          state_next_s = ST_ROUND;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ROUND: begin
        if (bus.stop) begin
          state_next_s = ST_IDLE;
        end else begin
          round_en_s = 1'b1;
          if (t_r == 6'd63) begin
            state_next_s = ST_FINAL;
          end else begin
            state_next_s = ST_ROUND;
          end
        end
      end
      ST_FINAL: begin
        if (bus.stop) begin
          state_next_s = ST_IDLE;
        end else begin
          final_s      = 1'b1;
          state_next_s = ST_OUT;
        end
      end
      ST_OUT: begin
        if (bus.stop) begin
          state_next_s = ST_IDLE;
        end else if (digest_valid_r && bus.digest_ready) begin
          if (nonce_r == NONCE_END) begin
            done_set_s   = 1'b1;
            state_next_s = ST_DONE;
          end else begin
            load_next_s  = 1'b1;
            state_next_s = ST_ROUND;
          end
        end else begin
          state_next_s = ST_OUT;
        end
      end
      ST_DONE: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State register and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      digest_valid_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s != ST_IDLE);
      done_r  <= done_set_s;
      if (final_s) begin
        digest_valid_r <= 1'b1;
      end else if (state_next_s == ST_OUT) begin
        digest_valid_r <= digest_valid_r;
      end else begin
        digest_valid_r <= 1'b0;
      end
    end
  end

  // Latched inputs, nonce counter, working state, schedule window and digest.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hp_r           <= '0;
      tail_r         <= '0;
      nonce_r        <= 32'h0000_0000;
      st_r           <= '0;
      w_r            <= '0;
      t_r            <= 6'd0;
      digest_r       <= '0;
      digest_nonce_r <= 32'h0000_0000;
    end else begin
      if (load_start_s) begin
        hp_r    <= bus.h_prev;
        tail_r  <= bus.msg_tail;
        nonce_r <= NONCE_START;
        st_r    <= bus.h_prev;
        w_r     <= build_block(bus.msg_tail, NONCE_START);
        t_r     <= 6'd0;
      end else if (load_next_s) begin
        nonce_r <= nonce_r + 32'd1;
        st_r    <= hp_r;
        w_r     <= build_block(tail_r, nonce_r + 32'd1);
        t_r     <= 6'd0;
      end else if (round_en_s) begin
        st_r <= rnd_state_s;
        w_r  <= {w_next_s, w_r[15:1]};
        t_r  <= t_r + 6'd1;
      end else begin
        st_r <= st_r;
      end
      if (final_s) begin
        digest_r       <= add_words(hp_r, st_r);
        digest_nonce_r <= nonce_r;
      end else begin
        digest_r <= digest_r;
      end
    end
  end

  assign bus.busy         = busy_r;
  assign bus.done         = done_r;
  assign bus.digest_valid = digest_valid_r;
  assign bus.digest       = digest_r;
  assign bus.digest_nonce = digest_nonce_r;

endmodule

// File: tb/tb_sha256_nonce_engine.sv
// Directed testbench for sha256_nonce_engine. Five engines with different
// nonce ranges share clock, reset and header data; expected digests come
// from an independent SHA-256 compression model.
module tb_sha256_nonce_engine;

  localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [31:0] NS [0:4] = '{32'h0000_0000, 32'h0000_0005, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFE};
  localparam logic [31:0] NE [0:4] = '{32'h0000_0000, 32'h0000_0007, 32'h0000_0003, 32'h1234_5678, 32'hFFFF_FFFF};

  localparam logic [31:0] KM [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic clk = 1'b0;
  logic reset;
  logic [4:0] start_v, stop_v, ready_v;
  logic [255:0] hp_s;
  logic [95:0] tail_s;
  wire  [4:0] valid_v, busy_v, done_v;
  wire  [255:0] dig_v [0:4];
  wire  [31:0] non_v [0:4];

  int checks = 0;
  int errors = 0;
  int n;
  int bad;
  logic [255:0] exp_d, held_d, hp_a;
  logic [95:0] tail_a;
  logic [31:0] held_n;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 5; gi++) begin : g
    sha256_nonce_engine_if bus ();
    assign bus.start        = start_v[gi];
    assign bus.stop         = stop_v[gi];
    assign bus.h_prev       = hp_s;
    assign bus.msg_tail     = tail_s;
    assign bus.digest_ready = ready_v[gi];
    assign valid_v[gi]      = bus.digest_valid;
    assign busy_v[gi]       = bus.busy;
    assign done_v[gi]       = bus.done;
    assign dig_v[gi]        = bus.digest;
    assign non_v[gi]        = bus.digest_nonce;
    sha256_nonce_engine #(.NONCE_START(NS[gi]), .NONCE_END(NE[gi])) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
    );
  end

  function automatic logic [31:0] rr(input logic [31:0] x, input int unsigned k);
    return (x >> k) | (x << (32 - k));
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [0:63];
    logic [31:0] v [0:7];
    logic [31:0] s0, s1, t1, t2;
    logic [255:0] r;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
    for (int i = 0; i < 64; i++) begin
      t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KM[i] + w[i];
      t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = hin[255 - 32*i -: 32] + v[i];
    return r;
  endfunction

  function automatic logic [255:0] expect_digest(input logic [255:0] hp, input logic [95:0] tail, input logic [31:0] nonce);
    logic [31:0] w3;
`ifdef NONCE_BYTESWAP_EN
    w3 = {nonce[7:0], nonce[15:8], nonce[23:16], nonce[31:24]};
`else
    w3 = nonce;
`endif
    return compress(hp, {tail, w3, 32'h8000_0000, 320'h0, 32'h0000_0280});
  endfunction

  task automatic do_start(input int i);
    @(negedge clk);
    start_v[i] = 1'b1;
    @(posedge clk);
    #1;
    start_v[i] = 1'b0;
  endtask

  // Returns edges elapsed until digest_valid is seen; equals budget on timeout.
  task automatic wait_valid(input int i, input int budget, output int cnt);
    cnt = 0;
    while (cnt < budget) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      if (valid_v[i] === 1'b1) break;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      checks++; if (valid_v[i] !== 1'b0) begin errors++; $display("FAIL reset_valid[%0d] got %b exp 0", i, valid_v[i]); end
      checks++; if (busy_v[i] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d] got %b exp 0", i, busy_v[i]); end
      checks++; if (done_v[i] !== 1'b0) begin errors++; $display("FAIL reset_done[%0d] got %b exp 0", i, done_v[i]); end
      checks++; if (dig_v[i] !== 256'h0) begin errors++; $display("FAIL reset_digest[%0d] got %h exp 0", i, dig_v[i]); end
      checks++; if (non_v[i] !== 32'h0) begin errors++; $display("FAIL reset_nonce[%0d] got %h exp 0", i, non_v[i]); end
    end
  endtask

  task automatic test_model_sanity();
    exp_d = compress(IV, {32'h6162_6380, 448'h0, 32'h0000_0018});
    checks++;
    if (exp_d !== 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad) begin
      errors++; $display("FAIL model_abc got %h", exp_d);
    end
  endtask

  task automatic test_single();
    hp_s = IV; tail_s = 96'h0; ready_v[0] = 1'b1;
    do_start(0);
    wait_valid(0, 100, n);
    checks++; if (n !== 65) begin errors++; $display("FAIL single_latency got %0d exp 65", n); end
    exp_d = expect_digest(IV, 96'h0, 32'h0);
    checks++; if (dig_v[0] !== exp_d) begin errors++; $display("FAIL single_digest got %h exp %h", dig_v[0], exp_d); end
    checks++; if (non_v[0] !== 32'h0) begin errors++; $display("FAIL single_nonce got %h exp 0", non_v[0]); end
    checks++; if (busy_v[0] !== 1'b1) begin errors++; $display("FAIL single_busy got %b exp 1", busy_v[0]); end
    @(posedge clk); @(negedge clk);
    checks++; if (done_v[0] !== 1'b1) begin errors++; $display("FAIL single_done got %b exp 1", done_v[0]); end
    checks++; if (valid_v[0] !== 1'b0) begin errors++; $display("FAIL single_valid_clr got %b exp 0", valid_v[0]); end
    @(posedge clk); @(negedge clk);
    checks++; if (done_v[0] !== 1'b0) begin errors++; $display("FAIL single_done_pulse got %b exp 0", done_v[0]); end
    checks++; if (busy_v[0] !== 1'b0) begin errors++; $display("FAIL single_idle got %b exp 0", busy_v[0]); end
  endtask

  task automatic test_start_stop_idle();
    @(negedge clk);
    start_v[0] = 1'b1; stop_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0; stop_v[0] = 1'b0;
    @(negedge clk);
    checks++; if (busy_v[0] !== 1'b1) begin errors++; $display("FAIL startstop_busy got %b exp 1", busy_v[0]); end
    repeat (10) @(posedge clk);
    @(negedge clk); start_v[0] = 1'b1;
    @(posedge clk); #1; start_v[0] = 1'b0;
    wait_valid(0, 100, n);
    checks++; if (n !== 54) begin errors++; $display("FAIL start_ignored_latency got %0d exp 54", n); end
    checks++; if (dig_v[0] !== exp_d) begin errors++; $display("FAIL start_ignored_digest got %h exp %h", dig_v[0], exp_d); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (busy_v[0] !== 1'b0) begin errors++; $display("FAIL startstop_end got %b exp 0", busy_v[0]); end
  endtask

  task automatic test_multi();
    hp_s = 256'h01234567_89abcdef_fedcba98_76543210_0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
    tail_s = 96'hdeadbeef_cafebabe_01234567;
    ready_v[1] = 1'b1;
    do_start(1);
    for (int k = 0; k < 3; k++) begin
      wait_valid(1, 100, n);
      held_n = 32'd5 + 32'(k);
      checks++; if (n !== ((k == 0) ? 65 : 66)) begin errors++; $display("FAIL multi_spacing%0d got %0d", k, n); end
      checks++; if (non_v[1] !== held_n) begin errors++; $display("FAIL multi_nonce%0d got %h exp %h", k, non_v[1], held_n); end
      exp_d = expect_digest(hp_s, tail_s, held_n);
      checks++; if (dig_v[1] !== exp_d) begin errors++; $display("FAIL multi_digest%0d got %h exp %h", k, dig_v[1], exp_d); end
    end
    @(posedge clk); @(negedge clk);
    checks++; if (done_v[1] !== 1'b1) begin errors++; $display("FAIL multi_done got %b exp 1", done_v[1]); end
    @(posedge clk); @(negedge clk);
    checks++; if (busy_v[1] !== 1'b0 || done_v[1] !== 1'b0) begin errors++; $display("FAIL multi_idle got busy %b done %b exp 0 0", busy_v[1], done_v[1]); end
    bad = 0;
    repeat (80) begin @(posedge clk); @(negedge clk); if (valid_v[1] !== 1'b0 || done_v[1] !== 1'b0) bad++; end
    checks++; if (bad != 0) begin errors++; $display("FAIL multi_quiet got %0d active cycles exp 0", bad); end
  endtask

  task automatic test_backpressure();
    hp_a = hp_s; tail_a = tail_s;
    ready_v[1] = 1'b0;
    do_start(1);
    hp_s = ~hp_s; tail_s = ~tail_s;
    wait_valid(1, 100, n);
    checks++; if (n !== 65) begin errors++; $display("FAIL bp_latency got %0d exp 65", n); end
    held_d = dig_v[1]; held_n = non_v[1];
    exp_d = expect_digest(hp_a, tail_a, 32'd5);
    checks++; if (held_d !== exp_d) begin errors++; $display("FAIL bp_digest got %h exp %h", held_d, exp_d); end
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if (valid_v[1] !== 1'b1 || dig_v[1] !== exp_d || non_v[1] !== 32'd5) begin
        errors++; $display("FAIL bp_hold%0d got valid %b nonce %h exp 1 5", c, valid_v[1], non_v[1]);
      end
    end
    ready_v[1] = 1'b1;
    wait_valid(1, 100, n);
    checks++; if (n !== 66) begin errors++; $display("FAIL bp_resume got %0d exp 66", n); end
    checks++; if (non_v[1] !== 32'd6) begin errors++; $display("FAIL bp_nonce got %h exp 6", non_v[1]); end
    exp_d = expect_digest(hp_a, tail_a, 32'd6);
    checks++; if (dig_v[1] !== exp_d) begin errors++; $display("FAIL bp_latched got %h exp %h", dig_v[1], exp_d); end
    stop_v[1] = 1'b1;
    @(posedge clk); #1; stop_v[1] = 1'b0;
    @(negedge clk);
    checks++; if (valid_v[1] !== 1'b0 || busy_v[1] !== 1'b0 || done_v[1] !== 1'b0) begin
      errors++; $display("FAIL stop_prio got valid %b busy %b done %b exp 0 0 0", valid_v[1], busy_v[1], done_v[1]);
    end
    bad = 0;
    repeat (70) begin @(posedge clk); @(negedge clk); if (valid_v[1] !== 1'b0 || busy_v[1] !== 1'b0) bad++; end
    checks++; if (bad != 0) begin errors++; $display("FAIL stop_prio_quiet got %0d active cycles exp 0", bad); end
    hp_s = hp_a; tail_s = tail_a;
  endtask

  task automatic test_stop();
    hp_s = IV; tail_s = 96'h00000001_00000002_00000003;
    ready_v[2] = 1'b1;
    do_start(2);
    wait_valid(2, 100, n);
    checks++; if (n !== 65 || non_v[2] !== 32'd0) begin errors++; $display("FAIL stop_first got n %0d nonce %h exp 65 0", n, non_v[2]); end
    repeat (30) @(posedge clk);
    @(negedge clk); stop_v[2] = 1'b1;
    @(posedge clk); #1; stop_v[2] = 1'b0;
    @(negedge clk);
    checks++; if (busy_v[2] !== 1'b0 || valid_v[2] !== 1'b0) begin errors++; $display("FAIL stop_idle got busy %b valid %b exp 0 0", busy_v[2], valid_v[2]); end
    bad = 0;
    repeat (150) begin @(posedge clk); @(negedge clk); if (valid_v[2] !== 1'b0 || done_v[2] !== 1'b0) bad++; end
    checks++; if (bad != 0) begin errors++; $display("FAIL stop_quiet got %0d active cycles exp 0", bad); end
    do_start(2);
    wait_valid(2, 100, n);
    checks++; if (n !== 65 || non_v[2] !== 32'd0) begin errors++; $display("FAIL restart got n %0d nonce %h exp 65 0", n, non_v[2]); end
    exp_d = expect_digest(IV, tail_s, 32'd0);
    checks++; if (dig_v[2] !== exp_d) begin errors++; $display("FAIL restart_digest got %h exp %h", dig_v[2], exp_d); end
    wait_valid(2, 100, n);
    exp_d = expect_digest(IV, tail_s, 32'd1);
    checks++; if (n !== 66 || dig_v[2] !== exp_d || non_v[2] !== 32'd1) begin
      errors++; $display("FAIL restart_second got n %0d nonce %h digest %h exp 66 1 %h", n, non_v[2], dig_v[2], exp_d);
    end
    stop_v[2] = 1'b1;
    @(posedge clk); #1; stop_v[2] = 1'b0;
  endtask

  task automatic test_byteswap();
    hp_s = IV; tail_s = 96'h01020304_05060708_090a0b0c;
    ready_v[3] = 1'b1;
    do_start(3);
    wait_valid(3, 100, n);
    checks++; if (n !== 65) begin errors++; $display("FAIL nonce_w3_latency got %0d exp 65", n); end
    checks++; if (non_v[3] !== 32'h1234_5678) begin errors++; $display("FAIL nonce_w3_report got %h exp 12345678", non_v[3]); end
    exp_d = expect_digest(IV, tail_s, 32'h1234_5678);
    checks++; if (dig_v[3] !== exp_d) begin errors++; $display("FAIL nonce_w3_digest got %h exp %h", dig_v[3], exp_d); end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_no_wrap();
    hp_s = IV; tail_s = 96'h0;
    ready_v[4] = 1'b1;
    do_start(4);
    wait_valid(4, 100, n);
    exp_d = expect_digest(IV, 96'h0, 32'hFFFF_FFFE);
    checks++; if (n !== 65 || non_v[4] !== 32'hFFFF_FFFE || dig_v[4] !== exp_d) begin
      errors++; $display("FAIL wrap_first got n %0d nonce %h exp 65 fffffffe", n, non_v[4]);
    end
    wait_valid(4, 100, n);
    exp_d = expect_digest(IV, 96'h0, 32'hFFFF_FFFF);
    checks++; if (n !== 66 || non_v[4] !== 32'hFFFF_FFFF || dig_v[4] !== exp_d) begin
      errors++; $display("FAIL wrap_last got n %0d nonce %h exp 66 ffffffff", n, non_v[4]);
    end
    @(posedge clk); @(negedge clk);
    checks++; if (done_v[4] !== 1'b1) begin errors++; $display("FAIL wrap_done got %b exp 1", done_v[4]); end
    bad = 0;
    repeat (80) begin @(posedge clk); @(negedge clk); if (valid_v[4] !== 1'b0 || busy_v[4] !== 1'b0) bad++; end
    checks++; if (bad != 0) begin errors++; $display("FAIL wrap_quiet got %0d active cycles exp 0", bad); end
  endtask

  task automatic test_async_reset();
    hp_s = IV; tail_s = 96'h0;
    do_start(0);
    repeat (20) @(posedge clk);
    #3;
    exp_d = expect_digest(IV, 96'h0, 32'h0);
    checks++; if (busy_v[0] !== 1'b1 || dig_v[0] !== exp_d) begin errors++; $display("FAIL areset_pre got busy %b digest %h", busy_v[0], dig_v[0]); end
    reset = 1'b1;
    #1;
    checks++; if (busy_v[0] !== 1'b0) begin errors++; $display("FAIL areset_busy got %b exp 0", busy_v[0]); end
    checks++; if (valid_v[0] !== 1'b0) begin errors++; $display("FAIL areset_valid got %b exp 0", valid_v[0]); end
    checks++; if (dig_v[0] !== 256'h0) begin errors++; $display("FAIL areset_digest got %h exp 0", dig_v[0]); end
    checks++; if (dig_v[1] !== 256'h0) begin errors++; $display("FAIL areset_digest1 got %h exp 0", dig_v[1]); end
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    repeat (10) begin @(posedge clk); @(negedge clk); if (done_v[0] !== 1'b0 || busy_v[0] !== 1'b0) bad++; end
    checks++; if (bad != 0) begin errors++; $display("FAIL areset_quiet got %0d active cycles exp 0", bad); end
  endtask

  initial begin
    reset = 1'b1;
    start_v = 5'b0; stop_v = 5'b0; ready_v = 5'b0;
    hp_s = 256'h0; tail_s = 96'h0;
    #12;
    test_reset();
    @(negedge clk);
    reset = 1'b0;
    test_model_sanity();
    test_single();
    test_start_stop_idle();
    test_multi();
    test_backpressure();
    test_stop();
    test_byteswap();
    test_no_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
